ef_smsdac_ctrl: RTL

//  Sample-rate scheduler and configuration controller in front of the segmented mismatch-shaping encoder.
//  - Buffers 8-bit DAC codes from upstream through a valid/ready interface.
//  - Releases one code per sample tick from a programmable divider; holds x/x7 constant between ticks.
//  - Drives a fresh 7-bit random selection word r and carry dither x_c every clock.
//  - Handles start-up priming, underflow and disable/flush.

---
 rtl/ef_smsdac_pkg.sv | 24 ++
 rtl/ef_smsdac_fifo.sv | 65 ++++++
 rtl/ef_smsdac_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ef_smsdac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_pkg
// Description : Shared constants for the mismatch-shaping DAC front-end
//               controller: midscale code, FSM state encoding, LFSR taps.
// Revision    : 1.0 - initial release
// ============================================================================
package ef_smsdac_pkg;

  // Offset-binary midscale: x = 0, x7 = 1
  localparam logic [7:0] MIDSCALE = 8'h80;

  // Controller states (explicit 2-bit encoding)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRIME = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  // Fibonacci x^15 + x^14 + 1: feedback = q[14] ^ q[13]
  localparam int LFSR_TAP_HI = 14;
  localparam int LFSR_TAP_LO = 13;

endpackage
`default_nettype wire

// File: rtl/ef_smsdac_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_fifo
// Description : Small synchronous sample FIFO with flush. Push is ignored
//               when full, pop when empty; flush overrides both.
// Revision    : 1.0 - initial release
// ============================================================================
module ef_smsdac_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_level == c_depth);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rdata  = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap freely
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ef_smsdac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ef_smsdac_ctrl
// Description : Sample-rate scheduler and configuration controller for the
//               segmented mismatch-shaping encoder. Buffers codes, releases
//               one per divider tick, and drives random selection / dither.
// Revision    : 1.0 - initial release
// ============================================================================
module ef_smsdac_ctrl
  import ef_smsdac_pkg::*;
#(
  parameter int                DW         = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter int                LFSR_W     = 15,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 15'h4A5B,
  parameter int                DIV_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [DW-1:0]                 in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_shape_en,
  input  logic                          cfg_dither_en,
  input  logic                          cfg_hold_last,
  input  logic                          clr_underflow,
  output logic [6:0]                    x,
  output logic                          x7,
  output logic                          x_c,
  output logic [6:0]                    r,
  output logic                          tick,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] c_prime_lvl = LW'(2);

  state_t            r_state;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div_q;
  logic [DW-1:0]     r_code;
  logic              r_underflow;
  logic [LFSR_W-1:0] r_lfsr;
  logic [6:0]        r_r;
  logic              r_xc;

  logic              w_tick;
  logic              w_enter_run;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic [DW-1:0]     w_head;
  logic              w_push;
  logic              w_pop;

  // Tick only while running and enabled; a dropping cfg_en suppresses it
  assign w_tick      = (r_state == ST_RUN) && cfg_en && (r_cnt == r_div_q);
  assign w_enter_run = cfg_en && (r_state == ST_PRIME) && (w_level >= c_prime_lvl);
  assign in_ready    = (r_state != ST_IDLE) && !w_full;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_tick && !w_empty;

  ef_smsdac_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (w_push),
    .wdata (in_data),
    .pop   (w_pop),
    .flush (!cfg_en),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Controller FSM: IDLE -> PRIME on enable, PRIME -> RUN with two buffered codes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else if (!cfg_en) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_PRIME;
        ST_PRIME: if (w_enter_run) r_state <= ST_RUN;
        ST_RUN:   r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Sample-period divider; period reloads at RUN entry and on each tick
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt   <= '0;
      r_div_q <= '0;
    end else if (r_state != ST_RUN || !cfg_en) begin
      r_cnt <= '0;
      if (w_enter_run) r_div_q <= cfg_div;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_div_q <= cfg_div;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output code register: FIFO head on tick, underflow policy when empty
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_code <= MIDSCALE;
    end else if (!cfg_en) begin
      r_code <= MIDSCALE;
    end else if (w_tick) begin
      if (!w_empty)           r_code <= w_head;
      else if (!cfg_hold_last) r_code <= MIDSCALE;
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_underflow <= 1'b0;
    end else if (w_tick && w_empty) begin
      r_underflow <= 1'b1;
    end else if (clr_underflow) begin
      r_underflow <= 1'b0;
    end
  end

  // LFSR advances outside IDLE; r and x_c sample its pre-shift value
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_lfsr <= LFSR_SEED;
      r_r    <= '0;
      r_xc   <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
      r_r    <= cfg_shape_en ? r_lfsr[6:0] : 7'd0;
      r_xc   <= (cfg_dither_en && cfg_en) ? r_lfsr[LFSR_TAP_HI] : 1'b0;
    end else begin
      r_xc   <= 1'b0;
    end
  end

  assign x          = r_code[6:0];
  assign x7         = r_code[DW-1];
  assign x_c        = r_xc;
  assign r          = r_r;
  assign tick       = w_tick;
  assign underflow  = r_underflow;
  assign fifo_level = w_level;

endmodule
`default_nettype wire
